puzzle_loader: RTL and testbench
================================

PUZZLE_LOADER -- requirements
Module: puzzle_loader

Interface
REQ-001 SHALL have parameter NUM_PUZZLES, default 8, meaning puzzles per difficulty bank.
REQ-002 SHALL have parameter CELLS, default 81, meaning cells per puzzle, row-major, 9x9.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  load request; sampled only in IDLE.
REQ-006 SHALL have port difficulty  input  1  bank select: 0 easy, 1 hard; latched on accepted start.
REQ-007 SHALL have port puzzle_sel  input  3  puzzle index; latched on accepted start.
REQ-008 SHALL have port maps_easy and maps_hard  input  2592 each  packed 4-bit digits.
REQ-009 SHALL have port visibilities_easy and visibilities_hard  input  1296 each  packed 2-bit visibility codes.
REQ-010 SHALL have port wr_valid  output  1  cell write valid toward board storage.
REQ-011 SHALL have port wr_ready  input  1  board storage accepts the write.
REQ-012 SHALL have port wr_addr  output  7  cell index 0..80.
REQ-013 SHALL have port wr_digit  output  4  solution digit of the cell.
REQ-014 SHALL have port wr_given  output  1  cell shown to the player at game start.
REQ-015 SHALL have port busy  output  1  high in LOAD and DONE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last cell is accepted.
REQ-017 SHALL have port loaded_idx  output  3  index of the most recently started puzzle.

Function
REQ-018 SHALL use FSM states IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE when cell CELLS-1 is accepted; DONE->IDLE unconditionally after one cycle.
REQ-019 SHALL compute flat cell index k = idx*CELLS + addr; digit = bank[2591-4k -: 4]; vis = bank[1295-2k -: 2] (MSB-first packing).
REQ-020 SHALL drive wr_given = 1 only for vis == 2'b11; codes 00, 01 and 10 SHALL give wr_given = 0.
REQ-021 SHALL register all outputs; wr_valid rises the cycle after start is accepted, with wr_addr = 0.
REQ-022 SHALL count a transfer only on wr_valid & wr_ready; after each transfer, wr_addr increments and the digit and given bits update on the next cycle.
REQ-023 SHALL hold wr_addr, wr_digit and wr_given stable while wr_valid & !wr_ready.
REQ-024 SHALL support back-to-back transfers: with wr_ready held high, a load completes in exactly 81 valid cycles.
REQ-025 SHALL deassert wr_valid in the cycle after the transfer of address 80 and assert done in that same cycle.
REQ-026 SHALL ignore start in LOAD and DONE; changes to difficulty and puzzle_sel during a load SHALL have no effect.
REQ-027 SHALL map puzzle_sel values >= NUM_PUZZLES (unreachable at the default of 8) by modulo NUM_PUZZLES.

Reset
REQ-028 SHALL, on rst_n low, immediately set state=IDLE, wr_valid=0, wr_addr=0, wr_digit=0, wr_given=0, busy=0, done=0, loaded_idx=0.
REQ-029 SHALL abandon an in-progress load on reset mid-operation, write nothing further, and restart only on a new start.

Configuration
REQ-030 SHALL, with macro SUDOKU_RANDOM_PICK_EN defined, run a free-running 3-bit counter (reset 0, increments every clock) and latch the counter value as idx on start, ignoring puzzle_sel.
REQ-031 SHALL, without SUDOKU_RANDOM_PICK_EN, latch idx from puzzle_sel and synthesize no counter.

Verification
REQ-032 SHALL cover: easy bank, puzzle_sel=0, start, wr_ready=1 -> first write addr 0, digit 3, given 1; 81 writes; done one cycle after addr 80.
REQ-033 SHALL cover: hard bank, puzzle_sel=0 -> addr 0 digit 2, given 1; all 81 digits match the packing formula for bank words.
REQ-034 SHALL cover: wr_ready toggled pseudo-randomly -> outputs stable while stalled; exactly 81 distinct accepted writes, in order 0..80.
REQ-035 SHALL cover: start pulsed during LOAD with different puzzle_sel -> ignored; loaded_idx unchanged.
REQ-036 SHALL cover: rst_n low at addr 40 -> outputs reset same edge; a new start reloads from addr 0.
REQ-037 SHALL cover: SUDOKU_RANDOM_PICK_EN defined, start at cycle 5 after reset -> loaded_idx = counter value at that edge (5 mod 8).

Source files
------------

// File: rtl/puzzle_loader.sv
// puzzle_loader: streams one 81-cell sudoku puzzle (digit + given flag) from a packed ROM bank to board storage.
// Optional macro SUDOKU_RANDOM_PICK_EN picks the puzzle from a free-running counter instead of puzzle_sel.
module puzzle_loader #(
   parameter int NUM_PUZZLES = 8,
   parameter int CELLS       = 81
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           difficulty,
   input  logic [2:0]                     puzzle_sel,
   input  logic [NUM_PUZZLES*CELLS*4-1:0] maps_easy,
   input  logic [NUM_PUZZLES*CELLS*4-1:0] maps_hard,
   input  logic [NUM_PUZZLES*CELLS*2-1:0] visibilities_easy,
   input  logic [NUM_PUZZLES*CELLS*2-1:0] visibilities_hard,
   output logic                           wr_valid,
   input  logic                           wr_ready,
   output logic [6:0]                     wr_addr,
   output logic [3:0]                     wr_digit,
   output logic                           wr_given,
   output logic                           busy,
   output logic                           done,
   output logic [2:0]                     loaded_idx
);

   localparam int MAP_W  = NUM_PUZZLES * CELLS * 4;
   localparam int VIS_W  = NUM_PUZZLES * CELLS * 2;
   localparam int MAP_AW = $clog2(MAP_W);
   localparam int VIS_AW = $clog2(VIS_W);
   localparam logic [6:0] LAST_ADDR = 7'(CELLS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t     state_q, state_d;
   logic       bank_q, bank_d;
   logic [2:0] idx_q, idx_d;
   logic [6:0] addr_q, addr_d;
   logic       wr_valid_q, wr_valid_d;
   logic [3:0] wr_digit_q, wr_digit_d;
   logic       wr_given_q, wr_given_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [2:0] loaded_idx_q, loaded_idx_d;

   logic [2:0] pick_idx;

`ifdef SUDOKU_RANDOM_PICK_EN
   logic [2:0] pick_cnt_q, pick_cnt_d;
   logic       unused_sel;

   assign unused_sel = ^puzzle_sel;
   assign pick_cnt_d = pick_cnt_q + 3'd1;
   assign pick_idx   = 3'(32'(pick_cnt_q) % NUM_PUZZLES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pick_cnt_q <= 3'd0;
      end else begin
         pick_cnt_q <= pick_cnt_d;
      end
   end
`else
   assign pick_idx = 3'(32'(puzzle_sel) % NUM_PUZZLES);
`endif

   // ROM lookup: in IDLE it prefetches cell 0 of the requested puzzle,
   // in LOAD it prefetches the cell following the one currently presented.
   logic              look_bank;
   logic [2:0]        look_idx;
   logic [6:0]        look_addr;
   logic [31:0]       look_k;
   logic [MAP_W-1:0]  look_map;
   logic [VIS_W-1:0]  look_vis;
   logic [MAP_AW-1:0] map_lsb;
   logic [VIS_AW-1:0] vis_lsb;
   logic [3:0]        look_digit;
   logic [1:0]        look_code;
   logic              look_given;

   always_comb begin
      if (state_q == IDLE) begin
         look_bank = difficulty;
         look_idx  = pick_idx;
         look_addr = 7'd0;
      end else begin
         look_bank = bank_q;
         look_idx  = idx_q;
         look_addr = (addr_q == LAST_ADDR) ? addr_q : addr_q + 7'd1;
      end
   end

   always_comb begin
      look_k     = 32'(look_idx) * 32'(CELLS) + 32'(look_addr);
      look_map   = look_bank ? maps_hard : maps_easy;
      look_vis   = look_bank ? visibilities_hard : visibilities_easy;
      // MSB-first packing: cell k occupies the k-th nibble counted from the top
      map_lsb    = MAP_AW'(MAP_W - 4 - 4 * look_k);
      vis_lsb    = VIS_AW'(VIS_W - 2 - 2 * look_k);
      look_digit = look_map[map_lsb +: 4];
      look_code  = look_vis[vis_lsb +: 2];
      look_given = (look_code == 2'b11);
   end

   always_comb begin
      state_d      = state_q;
      bank_d       = bank_q;
      idx_d        = idx_q;
      addr_d       = addr_q;
      wr_valid_d   = wr_valid_q;
      wr_digit_d   = wr_digit_q;
      wr_given_d   = wr_given_q;
      done_d       = 1'b0;
      loaded_idx_d = loaded_idx_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = LOAD;
               bank_d       = difficulty;
               idx_d        = pick_idx;
               loaded_idx_d = pick_idx;
               addr_d       = 7'd0;
               wr_valid_d   = 1'b1;
               wr_digit_d   = look_digit;
               wr_given_d   = look_given;
            end
         end
         LOAD: begin
            if (wr_valid_q && wr_ready) begin
               if (addr_q == LAST_ADDR) begin
                  state_d    = DONE;
                  wr_valid_d = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  addr_d     = addr_q + 7'd1;
                  wr_digit_d = look_digit;
                  wr_given_d = look_given;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bank_q       <= 1'b0;
         idx_q        <= 3'd0;
         addr_q       <= 7'd0;
         wr_valid_q   <= 1'b0;
         wr_digit_q   <= 4'd0;
         wr_given_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         loaded_idx_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         idx_q        <= idx_d;
         addr_q       <= addr_d;
         wr_valid_q   <= wr_valid_d;
         wr_digit_q   <= wr_digit_d;
         wr_given_q   <= wr_given_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         loaded_idx_q <= loaded_idx_d;
      end
   end

   assign wr_valid   = wr_valid_q;
   assign wr_addr    = addr_q;
   assign wr_digit   = wr_digit_q;
   assign wr_given   = wr_given_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign loaded_idx = loaded_idx_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// Self-checking bench for puzzle_loader: random puzzle banks held as digit/visibility arrays,
// random back-pressure, mid-load start pulses and a reset abort.
module tb_puzzle_loader;

   localparam int NP    = 8;
   localparam int NC    = 81;
   localparam int MAP_W = NP * NC * 4;
   localparam int VIS_W = NP * NC * 2;

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b1;
   logic             start      = 1'b0;
   logic             difficulty = 1'b0;
   logic [2:0]       puzzle_sel = 3'd0;
   logic [MAP_W-1:0] maps_easy, maps_hard;
   logic [VIS_W-1:0] vis_easy, vis_hard;
   logic             wr_valid;
   logic             wr_ready   = 1'b0;
   logic [6:0]       wr_addr;
   logic [3:0]       wr_digit;
   logic             wr_given;
   logic             busy;
   logic             done;
   logic [2:0]       loaded_idx;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference content: [bank][puzzle][cell]
   logic [3:0] dig_m [2][NP][NC];
   logic [1:0] vis_m [2][NP][NC];

   // Clock edges seen since reset release (value a free-running pick counter would hold)
   int edges_since_rst;

   logic [3:0] fd;
   logic       fg;

   puzzle_loader #(.NUM_PUZZLES(NP), .CELLS(NC)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .difficulty        (difficulty),
      .puzzle_sel        (puzzle_sel),
      .maps_easy         (maps_easy),
      .maps_hard         (maps_hard),
      .visibilities_easy (vis_easy),
      .visibilities_hard (vis_hard),
      .wr_valid          (wr_valid),
      .wr_ready          (wr_ready),
      .wr_addr           (wr_addr),
      .wr_digit          (wr_digit),
      .wr_given          (wr_given),
      .busy              (busy),
      .done              (done),
      .loaded_idx        (loaded_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges_since_rst <= 0;
      else        edges_since_rst <= edges_since_rst + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_valid"},   wr_valid,   0);
      check({tag, "_wr_addr"},    wr_addr,    0);
      check({tag, "_wr_digit"},   wr_digit,   0);
      check({tag, "_wr_given"},   wr_given,   0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_done"},       done,       0);
      check({tag, "_loaded_idx"}, loaded_idx, 0);
   endtask

   // Runs one load starting at a negedge; ends at a negedge one cycle after done,
   // or right after asserting reset when abort_at is reached.
   task automatic do_load(input logic diff, input logic [2:0] sel, input int ready_pct,
                          input int pulse_at, input int abort_at,
                          output logic [3:0] first_digit, output logic first_given);
      int         exp_addr;
      int         cycles;
      int         b;
      logic [2:0] exp_idx;
      logic       stalled;
      logic [6:0] p_addr;
      logic [3:0] p_dig;
      logic       p_giv;

      b = diff ? 1 : 0;
`ifdef SUDOKU_RANDOM_PICK_EN
      exp_idx = 3'(edges_since_rst % NP);
`else
      exp_idx = 3'(int'(sel) % NP);
`endif
      start      = 1'b1;
      difficulty = diff;
      puzzle_sel = sel;
      wr_ready   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("loaded_idx_latched", loaded_idx, exp_idx);
      first_digit = wr_digit;
      first_given = wr_given;

      exp_addr = 0;
      cycles   = 0;
      stalled  = 1'b0;
      p_addr   = '0;
      p_dig    = '0;
      p_giv    = 1'b0;
      while (exp_addr < NC && cycles < 4000) begin
         if (exp_addr == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            $display("load: bank=%0d idx=%0d aborted by reset at addr %0d", b, exp_idx, exp_addr);
            return;
         end
         check("wr_valid", wr_valid, 1);
         check("wr_addr", wr_addr, exp_addr);
         check("wr_digit", wr_digit, dig_m[b][exp_idx][exp_addr]);
         check("wr_given", wr_given, vis_m[b][exp_idx][exp_addr] == 2'b11);
         check("done_during_load", done, 0);
         check("loaded_idx_hold", loaded_idx, exp_idx);
         if (stalled) begin
            check("stall_addr", wr_addr, p_addr);
            check("stall_digit", wr_digit, p_dig);
            check("stall_given", wr_given, p_giv);
         end
         p_addr = wr_addr;
         p_dig  = wr_digit;
         p_giv  = wr_given;

         wr_ready   = ($urandom_range(99) < ready_pct);
         puzzle_sel = 3'($urandom);
         difficulty = 1'($urandom);
         start      = 1'b0;
         if (cycles == pulse_at) begin
            start      = 1'b1;
            puzzle_sel = sel ^ 3'd7;
         end
         stalled = !wr_ready;
         @(negedge clk);
         if (!stalled) exp_addr++;
         cycles++;
      end
      start    = 1'b0;
      wr_ready = 1'b0;
      check("accepted_writes", exp_addr, NC);
      if (ready_pct >= 100) check("back_to_back_cycles", cycles, NC);
      check("wr_valid_after_last", wr_valid, 0);
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 1);
      check("loaded_idx_final", loaded_idx, exp_idx);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_back_idle", busy, 0);
      check("wr_valid_idle", wr_valid, 0);
      $display("load: bank=%0d idx=%0d cycles=%0d writes=%0d", b, exp_idx, cycles, exp_addr);
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int p = 0; p < NP; p++)
            for (int a = 0; a < NC; a++) begin
               dig_m[b][p][a] = 4'($urandom_range(1, 9));
               vis_m[b][p][a] = 2'($urandom_range(0, 3));
            end
      dig_m[0][0][0] = 4'd3;
      vis_m[0][0][0] = 2'b11;
      dig_m[1][0][0] = 4'd2;
      vis_m[1][0][0] = 2'b11;
      maps_easy = '0;
      maps_hard = '0;
      vis_easy  = '0;
      vis_hard  = '0;
      for (int p = 0; p < NP; p++)
         for (int a = 0; a < NC; a++) begin
            maps_easy[MAP_W-1-4*(p*NC+a) -: 4] = dig_m[0][p][a];
            maps_hard[MAP_W-1-4*(p*NC+a) -: 4] = dig_m[1][p][a];
            vis_easy[VIS_W-1-2*(p*NC+a) -: 2]  = vis_m[0][p][a];
            vis_hard[VIS_W-1-2*(p*NC+a) -: 2]  = vis_m[1][p][a];
         end

      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("idle_wr_valid", wr_valid, 0);
         check("idle_busy", busy, 0);
      end

      do_load(1'b0, 3'd0, 100, -1, -1, fd, fg);
`ifdef SUDOKU_RANDOM_PICK_EN
      check("pick_at_cycle5", loaded_idx, 3'd5);
`else
      check("easy_first_digit", fd, 4'd3);
      check("easy_first_given", fg, 1);
`endif

      do_load(1'b1, 3'd0, 100, -1, -1, fd, fg);
`ifndef SUDOKU_RANDOM_PICK_EN
      check("hard_first_digit", fd, 4'd2);
      check("hard_first_given", fg, 1);
`endif

      do_load(1'b0, 3'($urandom), 50, -1, -1, fd, fg);
      do_load(1'b1, 3'd5, 70, 20, -1, fd, fg);

      do_load(1'b0, 3'd6, 100, -1, 40, fd, fg);
      @(negedge clk);
      check_reset_outputs("reset_held");
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_abort_no_write", wr_valid, 0);
         check("post_abort_idle", busy, 0);
      end
      do_load(1'b0, 3'd6, 60, -1, -1, fd, fg);

      for (int i = 0; i < 3; i++) begin
         do_load(1'($urandom), 3'($urandom), 40 + 20 * i, 10 * i + 3, -1, fd, fg);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
